// File: rtl/cute_key_sequencer_if.sv
// Bundles the sequencer's key-programming port, realign strobe and key/window outputs.
interface cute_key_sequencer_if #(parameter int KEY_W = 16);
  logic             sync;
  logic             wr_en;
  logic [2:0]       wr_idx;
  logic [KEY_W-1:0] wr_data;
  logic             commit;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [2:0]       win_idx;
  logic [6:0]       cnt;
  logic             wr_err;

  modport master (
    output sync, wr_en, wr_idx, wr_data, commit,
    input  key_out, key_valid, win_idx, cnt, wr_err
  );

  modport slave (
    input  sync, wr_en, wr_idx, wr_data, commit,
    output key_out, key_valid, win_idx, cnt, wr_err
  );
endinterface

// File: rtl/cute_key_sequencer.sv
// Per-window key driver: mirrors the lock's window counter and presents the slot key
// for the upcoming window on a registered bus; slots are writable until sealed.
module cute_key_sequencer #(
  parameter int                         KEY_W    = 16,
  parameter int                         NUM_WIN  = 5,
  parameter int                         WIN_LEN  = 13,
  parameter logic [NUM_WIN*KEY_W-1:0]   KEY_INIT = '0
) (
  input logic                 clk,
  input logic                 rst,
  cute_key_sequencer_if.slave bus
);
  localparam int PERIOD = NUM_WIN * WIN_LEN;

  typedef enum logic {OPEN, SEALED} seal_e;
  seal_e state, state_n;

  logic [6:0]                      cnt_q, cnt_n;
  logic [6:0]                      wcnt_q, wcnt_n;
  logic [2:0]                      win_q, win_n;
  logic [NUM_WIN-1:0][KEY_W-1:0]   slot;
  logic [KEY_W-1:0]                key_q, key_n;
  logic                            err_q;
  logic                            wr_ok, wr_bad;

  always_comb begin
    wr_bad = bus.wr_en && (state == SEALED || bus.wr_idx >= 3'(NUM_WIN));
    wr_ok  = bus.wr_en && !wr_bad;
  end

  // Window index tracked with an in-window counter so no divider is needed.
  always_comb begin
    cnt_n  = cnt_q + 7'd1;
    wcnt_n = wcnt_q + 7'd1;
    win_n  = win_q;
    if (bus.sync || cnt_q == 7'(PERIOD - 1)) begin
      cnt_n  = '0;
      wcnt_n = '0;
      win_n  = '0;
    end else if (wcnt_q == 7'(WIN_LEN - 1)) begin
      wcnt_n = '0;
      win_n  = win_q + 3'd1;
    end
  end

  // Next key comes from the window being entered; a same-cycle write to it wins.
  always_comb begin
    key_n = slot[0];
    for (int i = 0; i < NUM_WIN; i++)
      if (win_n == 3'(i))
        key_n = (wr_ok && bus.wr_idx == 3'(i)) ? bus.wr_data : slot[i];
  end

  always_comb begin
    state_n = state;
    if (state == OPEN && bus.commit) state_n = SEALED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OPEN;
      cnt_q  <= '0;
      wcnt_q <= '0;
      win_q  <= '0;
      slot   <= KEY_INIT;
      key_q  <= KEY_INIT[KEY_W-1:0];
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt_q  <= cnt_n;
      wcnt_q <= wcnt_n;
      win_q  <= win_n;
      key_q  <= key_n;
      if (wr_bad) err_q <= 1'b1;
      for (int i = 0; i < NUM_WIN; i++)
        if (wr_ok && bus.wr_idx == 3'(i)) slot[i] <= bus.wr_data;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.win_idx   = win_q;
  assign bus.key_out   = key_q;
  assign bus.key_valid = (state == SEALED);
  assign bus.wr_err    = err_q;
endmodule

// File: tb/tb_cute_key_sequencer.sv
// Directed bench: one DUT preloaded with the reference keys, one zero-initialised,
// both fed the same stimulus.
module tb_cute_key_sequencer;
  localparam logic [79:0] KEYS_INIT = {16'h94B6, 16'hD940, 16'h0236, 16'h63DC, 16'hFCD6};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync = 1'b0, wr_en = 1'b0, commit = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [15:0] wr_data = '0;

  int n_tests = 0, n_fail = 0;

  logic [15:0] keys [5] = '{16'hFCD6, 16'h63DC, 16'h0236, 16'hD940, 16'h94B6};
  logic [15:0] ka [5];
  int          ecnt;
  logic        esl, eerr;

  cute_key_sequencer_if #(.KEY_W(16)) ia ();
  cute_key_sequencer_if #(.KEY_W(16)) ib ();

  assign ia.sync = sync;   assign ib.sync = sync;
  assign ia.wr_en = wr_en; assign ib.wr_en = wr_en;
  assign ia.wr_idx = wr_idx; assign ib.wr_idx = wr_idx;
  assign ia.wr_data = wr_data; assign ib.wr_data = wr_data;
  assign ia.commit = commit; assign ib.commit = commit;

  cute_key_sequencer #(.KEY_W(16), .NUM_WIN(5), .WIN_LEN(13), .KEY_INIT(KEYS_INIT))
    u_dut_a (.clk(clk), .rst(rst), .bus(ia));
  cute_key_sequencer #(.KEY_W(16), .NUM_WIN(5), .WIN_LEN(13), .KEY_INIT(80'h0))
    u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (ecnt=%0d): got %h expected %h", nm, ecnt, act, exp);
    end
  endtask

  // Reference model of DUT A advanced on the current inputs, then checked after the edge.
  task automatic tick();
    if (rst) begin
      ecnt = 0; esl = 1'b0; eerr = 1'b0;
      for (int i = 0; i < 5; i++) ka[i] = keys[i];
    end else begin
      if (wr_en) begin
        if (esl || wr_idx >= 3'd5) eerr = 1'b1;
        else ka[wr_idx] = wr_data;
      end
      if (commit) esl = 1'b1;
      ecnt = (sync || ecnt == 64) ? 0 : ecnt + 1;
    end
    @(posedge clk); #1;
    chk("a_cnt",   32'(ia.cnt),       32'(ecnt));
    chk("a_win",   32'(ia.win_idx),   32'(ecnt / 13));
    chk("a_key",   32'(ia.key_out),   32'(ka[ecnt / 13]));
    chk("a_valid", 32'(ia.key_valid), 32'(esl));
    chk("a_err",   32'(ia.wr_err),    32'(eerr));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 70 && ecnt != target; i++) tick();
  endtask

  typedef struct {
    string       nm;
    logic        rst, wr_en, commit;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        exp_valid, exp_err;
  } vec_t;
  vec_t vt [10];

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst = vt[i].rst; wr_en = vt[i].wr_en; commit = vt[i].commit;
      wr_idx = vt[i].idx; wr_data = vt[i].data;
      tick();
      chk({"b_valid_", vt[i].nm}, 32'(ib.key_valid), 32'(vt[i].exp_valid));
      chk({"b_err_", vt[i].nm},   32'(ib.wr_err),    32'(vt[i].exp_err));
      rst = 1'b0; wr_en = 1'b0; commit = 1'b0;
    end
  endtask

  initial begin
    vt[0] = '{"w0",     1'b0, 1'b1, 1'b0, 3'd0, 16'hFCD6, 1'b0, 1'b0};
    vt[1] = '{"w1",     1'b0, 1'b1, 1'b0, 3'd1, 16'h63DC, 1'b0, 1'b0};
    vt[2] = '{"w2",     1'b0, 1'b1, 1'b0, 3'd2, 16'h0236, 1'b0, 1'b0};
    vt[3] = '{"w3",     1'b0, 1'b1, 1'b0, 3'd3, 16'hD940, 1'b0, 1'b0};
    vt[4] = '{"w4_cmt", 1'b0, 1'b1, 1'b1, 3'd4, 16'h94B6, 1'b1, 1'b0};
    vt[5] = '{"w_seal", 1'b0, 1'b1, 1'b0, 3'd2, 16'hFFFF, 1'b1, 1'b1};
    vt[6] = '{"idle",   1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1};
    vt[7] = '{"rst",    1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vt[8] = '{"idx5",   1'b0, 1'b1, 1'b0, 3'd5, 16'h1234, 1'b0, 1'b1};
    vt[9] = '{"idx7",   1'b0, 1'b1, 1'b0, 3'd7, 16'h5678, 1'b0, 1'b1};

    // Reset defaults
    rst = 1'b1;
    tick(); tick();
    chk("b_rst_key", 32'(ib.key_out), 32'h0);
    rst = 1'b0;

    // Two full periods from reset on the preloaded keys
    for (int i = 0; i < 130; i++) tick();
    chk("wrap_cnt", 32'(ia.cnt), 32'd0);

    // Program and seal DUT B, then confirm its store over one period
    run_vecs(0, 7);
    for (int i = 0; i < 65; i++) begin
      tick();
      chk("b_store_key", 32'(ib.key_out), 32'(keys[ecnt / 13]));
    end

    // Reset, then illegal indices; store must stay intact for a full period
    run_vecs(7, 10);
    for (int i = 0; i < 65; i++) tick();

    // Bypass: write slot 1 while cnt=12
    run_to(12);
    wr_en = 1'b1; wr_idx = 3'd1; wr_data = 16'hAAAA;
    tick();
    wr_en = 1'b0;
    chk("byp_cnt", 32'(ia.cnt), 32'd13);
    chk("byp_key", 32'(ia.key_out), 32'hAAAA);
    // Write to a later window shows up only on entering it
    wr_en = 1'b1; wr_idx = 3'd3; wr_data = 16'h5A5A;
    tick();
    wr_en = 1'b0;
    chk("late_key_hold", 32'(ia.key_out), 32'hAAAA);
    run_to(39);
    chk("late_key_show", 32'(ia.key_out), 32'h5A5A);

    // Sync mid-period and at the wrap point
    run_to(40);
    sync = 1'b1; tick(); sync = 1'b0;
    chk("sync_cnt", 32'(ia.cnt), 32'd0);
    chk("sync_win", 32'(ia.win_idx), 32'd0);
    chk("sync_key", 32'(ia.key_out), 32'hFCD6);
    tick();
    chk("sync_restart", 32'(ia.cnt), 32'd1);
    run_to(64);
    sync = 1'b1; tick(); sync = 1'b0;
    chk("sync64_cnt", 32'(ia.cnt), 32'd0);

    // Seal, then reset mid-period restores everything
    commit = 1'b1; tick(); commit = 1'b0;
    chk("seal_valid", 32'(ia.key_valid), 32'd1);
    wr_en = 1'b1; wr_idx = 3'd0; wr_data = 16'h0BAD; tick(); wr_en = 1'b0;
    run_to(30);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_cnt",   32'(ia.cnt),       32'd0);
    chk("mid_rst_valid", 32'(ia.key_valid), 32'd0);
    chk("mid_rst_err",   32'(ia.wr_err),    32'd0);
    chk("mid_rst_key",   32'(ia.key_out),   32'hFCD6);
    for (int i = 0; i < 65; i++) begin
      tick();
      chk("restored_key", 32'(ia.key_out), 32'(keys[ecnt / 13]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
